// File: rtl/layer_weight_loader.sv
// Avalon-MM initiator: streams weights into consecutive PIO weight registers, optionally reading each back.
// 2 cycles/weight (3 with readback) + 1 per waitrequest cycle; in_ready only in FETCH, bus outputs frozen during waitrequest.
module layer_weight_loader #(
    parameter int          NUM_WEIGHTS = 16,
    parameter int          WEIGHT_W    = 17,
    parameter int          ADDR_W      = 16,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned STRIDE      = 16,
    parameter bit          VERIFY      = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [WEIGHT_W-1:0]          in_data,
    output logic                         in_ready,
    output logic [ADDR_W-1:0]            avm_address,
    output logic                         avm_chipselect,
    output logic                         avm_write_n,
    output logic [31:0]                  avm_writedata,
    input  logic [31:0]                  avm_readdata,
    input  logic                         avm_waitrequest,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(NUM_WEIGHTS):0] err_index
);
    localparam int                IDX_W    = $clog2(NUM_WEIGHTS) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WEIGHTS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, READ, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] index;
    logic             xfer_done;
    logic             read_ok;
    logic             advance;

    assign in_ready  = (state == FETCH);
    assign xfer_done = !avm_waitrequest;
    // avm_writedata keeps the zero-extended weight through READ, so it doubles as the weight register
    assign read_ok   = (avm_readdata == avm_writedata);
    assign advance   = xfer_done && ((state == WRITE && !VERIFY) || (state == READ && read_ok));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            index          <= '0;
            avm_address    <= BASE;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_index      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        error       <= 1'b0;
                        err_index   <= '0;
                        index       <= '0;
                        avm_address <= BASE;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        avm_writedata  <= 32'(in_data);
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    if (xfer_done && VERIFY) begin
                        avm_write_n <= 1'b1;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (xfer_done && !read_ok) begin
                        error          <= 1'b1;
                        err_index      <= index;
                        avm_chipselect <= 1'b0;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        state          <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (advance) begin
                avm_chipselect <= 1'b0;
                avm_write_n    <= 1'b1;
                if (index == LAST_IDX) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    index       <= index + 1'b1;
                    avm_address <= avm_address + STEP;
                    state       <= FETCH;
                end
            end
        end
    end
endmodule

// File: tb/tb_layer_weight_loader.sv
// Randomized bench for layer_weight_loader: reactive Avalon slave/stream driver, transaction list checked against a plan-derived model.
module tb_layer_weight_loader;
    localparam int NW  = 4;
    localparam int STR = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, in_valid = 1'b0, in_ready;
    logic [16:0] in_data = '0;
    logic [15:0] avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [31:0] avm_writedata, avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        busy, done, error;
    logic [2:0]  err_index;

    logic        start_b = 1'b0, in_valid_b = 1'b0, in_ready_b;
    logic [16:0] in_data_b = '0;
    logic [15:0] addr_b;
    logic        cs_b, wn_b;
    logic [31:0] wdata_b;
    logic [31:0] rdata_b = '0;
    logic        wait_b = 1'b0;
    logic        busy_b, done_b, error_b;
    logic [0:0]  err_index_b;

    int          errors = 0, checks = 0;
    logic [16:0] weights [NW];
    int          gap [NW], wstall [NW], rstall [NW];
    int          corrupt_idx;
    logic [31:0] cmask;
    logic [31:0] mem [NW];

    always #5 clk = ~clk;

    layer_weight_loader #(.NUM_WEIGHTS(NW), .WEIGHT_W(17), .ADDR_W(16), .BASE_ADDR(0),
                          .STRIDE(STR), .VERIFY(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done), .error(error),
        .err_index(err_index));

    layer_weight_loader #(.NUM_WEIGHTS(1), .WEIGHT_W(17), .ADDR_W(16), .BASE_ADDR(32'h100),
                          .STRIDE(STR), .VERIFY(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .avm_address(addr_b), .avm_chipselect(cs_b),
        .avm_write_n(wn_b), .avm_writedata(wdata_b), .avm_readdata(rdata_b),
        .avm_waitrequest(wait_b), .busy(busy_b), .done(done_b), .error(error_b),
        .err_index(err_index_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        check({tag, "_cs"},       32'(avm_chipselect), 32'(0));
        check({tag, "_write_n"},  32'(avm_write_n), 32'(1));
        check({tag, "_addr"},     32'(avm_address), 32'(0));
        check({tag, "_wdata"},    avm_writedata, 32'(0));
        check({tag, "_busy"},     32'(busy), 32'(0));
        check({tag, "_done"},     32'(done), 32'(0));
        check({tag, "_error"},    32'(error), 32'(0));
        check({tag, "_err_idx"},  32'(err_index), 32'(0));
    endtask

    task automatic clear_plan();
        for (int i = 0; i < NW; i++) begin
            gap[i] = 0; wstall[i] = 0; rstall[i] = 0;
        end
        corrupt_idx = -1;
        cmask = 32'h0002_0000;
    endtask

    task automatic run_a(input string name, input bit mid_start);
        int n_exp, exp_lat, busy_cyc, done_cyc, widx, gap_left, stall_left, idx, nq;
        bit offered, in_xfer, prev_stall, e_wr;
        logic [15:0] s_addr, e_addr;
        logic [31:0] s_data, e_data;
        logic        s_wn, s_cs;
        logic [15:0] q_addr [$];
        logic [31:0] q_data [$];
        bit          q_wr [$];
        busy_cyc = -1; done_cyc = -1; widx = 0; gap_left = gap[0]; stall_left = 0;
        offered = 0; in_xfer = 0; prev_stall = 0;
        s_addr = '0; s_data = '0; s_wn = 1'b1; s_cs = 1'b0;
        for (int i = 0; i < NW; i++) mem[i] = 32'hDEAD_0000;
        // Reference: each weight costs 3 cycles plus its planned gap and stall cycles; a mismatch truncates the run
        n_exp = (corrupt_idx >= 0) ? corrupt_idx + 1 : NW;
        exp_lat = 3 * n_exp;
        for (int i = 0; i < n_exp; i++) exp_lat += gap[i] + wstall[i] + rstall[i];

        in_valid = 1'b0; avm_waitrequest = 1'b0;
        @(negedge clk); start = 1'b1;
        for (int t = 1; t <= 400 && done_cyc < 0; t++) begin
            @(negedge clk);
            if (t == 1 || t == 7) start = 1'b0;
            if (mid_start && t == 6) start = 1'b1;
            if (t == 1) begin
                check({name, "_start_busy"}, 32'(busy), 32'(1));
                check({name, "_start_clr_err"}, 32'(error), 32'(0));
                check({name, "_start_clr_done"}, 32'(done), 32'(0));
                check({name, "_start_clr_eidx"}, 32'(err_index), 32'(0));
            end
            if (offered) begin
                widx++;
                gap_left = (widx < NW) ? gap[widx] : 0;
            end
            if (prev_stall) begin
                check({name, "_stall_addr"}, 32'(avm_address), 32'(s_addr));
                check({name, "_stall_wdata"}, avm_writedata, s_data);
                check({name, "_stall_wn"}, 32'(avm_write_n), 32'(s_wn));
                check({name, "_stall_cs"}, 32'(avm_chipselect), 32'(s_cs));
            end
            prev_stall = 0;
            if (avm_chipselect) begin
                idx = int'(avm_address) / STR;
                if (idx >= NW) idx = NW - 1;
                if (!in_xfer) begin
                    in_xfer = 1;
                    stall_left = avm_write_n ? rstall[idx] : wstall[idx];
                end
                if (stall_left > 0) begin
                    stall_left--;
                    avm_waitrequest = 1'b1;
                    prev_stall = 1;
                    s_addr = avm_address; s_data = avm_writedata; s_wn = avm_write_n; s_cs = avm_chipselect;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_xfer = 0;
                    q_addr.push_back(avm_address);
                    q_wr.push_back(!avm_write_n);
                    q_data.push_back(avm_write_n ? 32'h0 : avm_writedata);
                    if (!avm_write_n) mem[idx] = avm_writedata;
                    else avm_readdata = mem[idx] ^ ((idx == corrupt_idx) ? cmask : 32'h0);
                end
            end else begin
                avm_waitrequest = 1'b0;
                in_xfer = 0;
            end
            offered = 0;
            if (in_ready) begin
                if (gap_left > 0) begin
                    gap_left--;
                    in_valid = 1'b0;
                    check({name, "_gap_cs"}, 32'(avm_chipselect), 32'(0));
                end else begin
                    in_valid = 1'b1;
                    in_data = weights[(widx < NW) ? widx : 0];
                    offered = 1;
                end
            end else begin
                in_valid = 1'b0;
                in_data = 17'($urandom);
            end
            if (busy && busy_cyc < 0) busy_cyc = t;
            if (done) done_cyc = t;
        end
        start = 1'b0; in_valid = 1'b0; avm_waitrequest = 1'b0;

        check({name, "_done_seen"}, 32'(done_cyc >= 0), 32'(1));
        if (done_cyc >= 0) check({name, "_latency"}, 32'(done_cyc - busy_cyc), 32'(exp_lat));
        check({name, "_n_xfers"}, 32'(q_addr.size()), 32'(2 * n_exp));
        nq = (q_addr.size() < 2 * n_exp) ? q_addr.size() : 2 * n_exp;
        for (int i = 0; i < nq; i++) begin
            e_wr   = (i % 2 == 0);
            e_addr = 16'((i / 2) * STR);
            e_data = e_wr ? {15'b0, weights[i / 2]} : 32'h0;
            check({name, "_xfer_addr"}, 32'(q_addr[i]), 32'(e_addr));
            check({name, "_xfer_is_wr"}, 32'(q_wr[i]), 32'(e_wr));
            check({name, "_xfer_data"}, q_data[i], e_data);
        end
        for (int i = 0; i < n_exp; i++) check({name, "_mem"}, mem[i], {15'b0, weights[i]});
        check({name, "_error"}, 32'(error), 32'(corrupt_idx >= 0));
        check({name, "_err_idx"}, 32'(err_index), 32'((corrupt_idx >= 0) ? corrupt_idx : 0));
        check({name, "_done"}, 32'(done), 32'(1));
        check({name, "_busy"}, 32'(busy), 32'(0));
    endtask

    task automatic reset_mid_write();
        bit hit = 0;
        in_valid = 1'b0;
        @(negedge clk); start = 1'b1;
        for (int t = 1; t < 60 && !hit; t++) begin
            @(negedge clk);
            start = 1'b0;
            avm_waitrequest = 1'b0;
            avm_readdata = avm_writedata;
            in_valid = in_ready;
            in_data = 17'h0BEEF + 17'(t);
            if (avm_chipselect && !avm_write_n && avm_address == 16'h0010) hit = 1;
        end
        check("rst_reached_write1", 32'(hit), 32'(1));
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        check_reset_vals("rst_held");
        reset_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic run_b();
        int bc = -1, dc = -1, nw = 0, nr = 0;
        logic [16:0] w;
        w = 17'($urandom);
        in_valid_b = 1'b1; in_data_b = w;
        @(negedge clk); start_b = 1'b1;
        for (int t = 1; t <= 50 && dc < 0; t++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (cs_b) begin
                if (!wn_b) begin
                    nw++;
                    check("nv_addr", 32'(addr_b), 32'h100);
                    check("nv_wdata", wdata_b, {15'b0, w});
                end else nr++;
            end
            if (busy_b && bc < 0) bc = t;
            if (done_b) dc = t;
        end
        in_valid_b = 1'b0;
        check("nv_done_seen", 32'(dc >= 0), 32'(1));
        check("nv_writes", 32'(nw), 32'(1));
        check("nv_reads", 32'(nr), 32'(0));
        if (dc >= 0) check("nv_latency", 32'(dc - bc), 32'(2));
        check("nv_error", 32'(error_b), 32'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        check("reset_b_addr", 32'(addr_b), 32'h100);
        reset_n = 1'b1;
        @(negedge clk);

        clear_plan();
        weights[0] = 17'h1FFFF; weights[1] = 17'h00001; weights[2] = 17'h0AAAA; weights[3] = 17'h15555;
        run_a("basic", 1'b0);

        clear_plan();
        wstall[1] = 3; rstall[2] = 2;
        run_a("backpressure", 1'b1);

        clear_plan();
        gap[2] = 4;
        run_a("gaps", 1'b0);

        clear_plan();
        corrupt_idx = 2;
        run_a("mismatch", 1'b0);

        clear_plan();
        run_a("restart", 1'b0);

        reset_mid_write();
        clear_plan();
        for (int i = 0; i < NW; i++) weights[i] = 17'($urandom);
        run_a("after_reset", 1'b0);

        for (int r = 0; r < 8; r++) begin
            clear_plan();
            for (int i = 0; i < NW; i++) begin
                weights[i] = 17'($urandom);
                gap[i]     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
                wstall[i]  = int'($urandom_range(0, 2));
                rstall[i]  = int'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 3) == 0) begin
                corrupt_idx = int'($urandom_range(0, NW - 1));
                cmask = 32'h1 << $urandom_range(0, 31);
            end
            run_a("random", 1'($urandom_range(0, 1)));
        end

        run_b();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
